// File: rtl/time_gen.sv
// time_gen: timebase for the alarm-clock datapath.
// Divides clk256 into single-cycle one_second and one_minute strobes.
// fast_mode turns every second into a minute for demo/test acceleration.
// Optional build macro TIME_GEN_HOUR_EN adds a minutes counter and a
// one_hour strobe coincident with the minute strobe that wraps it.
module time_gen #(
    parameter int CLK_HZ        = 256,
    parameter int SECS_PER_MIN  = 60
`ifdef TIME_GEN_HOUR_EN
    ,
    parameter int MINS_PER_HOUR = 60
`endif
) (
    input  logic clk256,
    input  logic reset,       // asynchronous, active-low
    input  logic fast_mode,
    output logic one_second,
    output logic one_minute
`ifdef TIME_GEN_HOUR_EN
    ,
    output logic one_hour
`endif
);

    localparam int TICK_W = $clog2(CLK_HZ);
    localparam int SEC_W  = $clog2(SECS_PER_MIN);

    logic [TICK_W-1:0] tick_q, tick_d;
    logic [SEC_W-1:0]  sec_q, sec_d;
    logic              tick_wrap;
    logic              sec_pulse_d, min_pulse_d;
    logic              one_second_q, one_minute_q;

    // Prescaler and seconds counter next-state; strobes are decided here and
    // registered below so both outputs come straight from flops.
    always_comb begin
        tick_wrap   = (tick_q == TICK_W'(CLK_HZ - 1));
        tick_d      = tick_wrap ? '0 : tick_q + 1'b1;
        sec_pulse_d = tick_wrap;
        sec_d       = sec_q;
        min_pulse_d = 1'b0;
        if (fast_mode) begin
            // Seconds held at 0 so a later return to normal mode restarts
            // a full minute from the last fast strobe.
            sec_d       = '0;
            min_pulse_d = tick_wrap;
        end else if (tick_wrap) begin
            if (sec_q == SEC_W'(SECS_PER_MIN - 1)) begin
                sec_d       = '0;
                min_pulse_d = 1'b1;
            end else begin
                sec_d = sec_q + 1'b1;
            end
        end
    end

    // Counter and strobe registers; reset clears everything immediately.
    always_ff @(posedge clk256 or negedge reset) begin
        if (!reset) begin
            tick_q       <= '0;
            sec_q        <= '0;
            one_second_q <= 1'b0;
            one_minute_q <= 1'b0;
        end else begin
            tick_q       <= tick_d;
            sec_q        <= sec_d;
            one_second_q <= sec_pulse_d;
            one_minute_q <= min_pulse_d;
        end
    end

    assign one_second = one_second_q;
    assign one_minute = one_minute_q;

`ifdef TIME_GEN_HOUR_EN
    localparam int MIN_W = $clog2(MINS_PER_HOUR);

    logic [MIN_W-1:0] min_q, min_d;
    logic             hour_pulse_d;
    logic             one_hour_q;

    // Minutes counter advances on every minute strobe, fast-mode ones included.
    always_comb begin
        min_d        = min_q;
        hour_pulse_d = 1'b0;
        if (min_pulse_d) begin
            if (min_q == MIN_W'(MINS_PER_HOUR - 1)) begin
                min_d        = '0;
                hour_pulse_d = 1'b1;
            end else begin
                min_d = min_q + 1'b1;
            end
        end
    end

    // Minutes counter and hour strobe registers.
    always_ff @(posedge clk256 or negedge reset) begin
        if (!reset) begin
            min_q      <= '0;
            one_hour_q <= 1'b0;
        end else begin
            min_q      <= min_d;
            one_hour_q <= hour_pulse_d;
        end
    end

    assign one_hour = one_hour_q;
`endif

endmodule

// File: tb/tb_time_gen.sv
// tb_time_gen: directed bench for time_gen.
// Edges are counted from reset release; expected strobes are computed from
// the edge number (seconds every 256 edges, minutes every 15360 edges or with
// every second while fast_mode is in effect).
module tb_time_gen;

    localparam int SEC_EDGES = 256;
    localparam int MIN_EDGES = 256 * 60;

    logic clk256;
    logic reset;
    logic fast_mode;
    logic one_second;
    logic one_minute;
`ifdef TIME_GEN_HOUR_EN
    logic one_hour;
`endif

    int n_checks;
    int n_errors;
    int ecnt;        // rising edges since reset release
    int fast_until;  // edges <= this were generated with fast_mode=1
    int min_origin;  // edge of the last minute reference point
    int hour_edge;   // edge at which one_hour is expected (-1: never)

    time_gen dut (
        .clk256     (clk256),
        .reset      (reset),
        .fast_mode  (fast_mode),
        .one_second (one_second),
        .one_minute (one_minute)
`ifdef TIME_GEN_HOUR_EN
        ,
        .one_hour   (one_hour)
`endif
    );

    // clock: 10 ns period
    initial clk256 = 1'b0;
    always #5 clk256 = ~clk256;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $display("FAIL %s at edge %0d: observed %b expected %b", tag, ecnt, obs, exp);
            $error("check %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_sec"}, one_second, 1'b0);
        chk({tag, "_min"}, one_minute, 1'b0);
`ifdef TIME_GEN_HOUR_EN
        chk({tag, "_hour"}, one_hour, 1'b0);
`endif
    endtask

    // Advance n edges, checking every strobe #1 after each rising edge.
    task automatic run_edges(input int n, input string tag);
        logic exp_sec, exp_min;
        for (int i = 0; i < n; i++) begin
            @(posedge clk256);
            #1;
            ecnt++;
            exp_sec = (ecnt % SEC_EDGES) == 0;
            exp_min = exp_sec && ((ecnt <= fast_until) ||
                      (ecnt > min_origin && ((ecnt - min_origin) % MIN_EDGES) == 0));
            chk({tag, "_sec"}, one_second, exp_sec);
            chk({tag, "_min"}, one_minute, exp_min);
`ifdef TIME_GEN_HOUR_EN
            chk({tag, "_hour"}, one_hour, logic'(ecnt == hour_edge));
`endif
        end
    endtask

    // Hold reset low for n cycles, checking outputs stay 0, then release at a negedge.
    task automatic reset_and_release(input int n, input string tag);
        reset = 1'b0;
        #1;
        chk_all_zero({tag, "_async"});
        for (int i = 0; i < n; i++) begin
            @(posedge clk256);
            #1;
            chk_all_zero({tag, "_held"});
        end
        @(negedge clk256);
        reset = 1'b1;
        ecnt  = 0;
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        ecnt       = 0;
        fast_until = 0;
        min_origin = 0;
        hour_edge  = -1;
        reset      = 1'b0;
        fast_mode  = 1'b0;

        // Power-up reset, normal mode: first 100 cycles silent, first second
        // at edge 256, single minute at edge 15360 within 20000 edges.
        reset_and_release(3, "por");
        run_edges(100, "window");
        run_edges(20000 - 100, "normal");

        // Mid-count reset right while one_second is high: it must drop at once,
        // and timing after release must match power-up.
        reset_and_release(2, "pre_mid");
        run_edges(10240, "pre_mid");
        #1;
        reset_and_release(2, "mid");
        run_edges(MIN_EDGES + 10, "after_mid");

        // Fast mode from reset: minute with every second.
        fast_mode  = 1'b1;
        fast_until = 1 << 30;
        min_origin = 1 << 30;
        reset_and_release(3, "fast");
        run_edges(1100, "fast");

        // Leave fast mode mid-second: next minute 60 s after last fast strobe (1024).
        fast_mode  = 1'b0;
        fast_until = 1100;
        min_origin = 1024;
        run_edges(16400 - 1100, "fast_to_norm");

`ifdef TIME_GEN_HOUR_EN
        // Fast mode: 60th minute strobe at edge 15360 carries one_hour.
        fast_mode  = 1'b1;
        fast_until = 1 << 30;
        min_origin = 1 << 30;
        hour_edge  = MIN_EDGES;
        reset_and_release(2, "hour");
        run_edges(MIN_EDGES + 10, "hour");
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
